// File: rtl/lcd_hd44780_model.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_model
//
// Behavioural responder for an 8-bit HD44780-style character LCD bus. Samples
// lcd_data/lcd_rs on each falling edge of lcd_en, decodes instructions and data
// writes, and keeps a 16-character single-line DDRAM plus cursor and mode
// registers. A read port and status outputs expose what the display would show.
//
// Optional feature macro: LCD_MODEL_BUSY_EN
//   defined   : accepted commands/data hold busy for CMD_CYCLES, clear holds
//               busy for 16 + CLEAR_CYCLES.
//   undefined : busy only during the 16-cycle clear sweep.
//
// Parameters:
//   CMD_CYCLES   - busy length after a non-clear command or data write (>= 1)
//   CLEAR_CYCLES - busy length after the clear sweep (>= 16)
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   lcd_data, lcd_en,   - LCD bus; transfer latched on falling edge of lcd_en,
//   lcd_rs                lcd_rs 0 = instruction, 1 = data
//   rd_addr / rd_char   - DDRAM read port, registered, 1-cycle latency
//   cursor              - address counter
//   disp_on, cursor_on, blink_on - display-control bits
//   func_8bit, func_2line        - function-set bits
//   inc_mode            - entry mode, 1 = increment, 0 = decrement
//   wr_strobe           - one-cycle pulse per committed data character
//   last_char           - last committed data character
//   busy                - strobes are ignored while high
//   err_overrun         - sticky, strobe arrived while busy
// -----------------------------------------------------------------------------
module lcd_hd44780_model #(
    parameter int CMD_CYCLES   = 40,
    parameter int CLEAR_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_data,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [3:0] cursor,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       func_8bit,
    output logic       func_2line,
    output logic       inc_mode,
    output logic       wr_strobe,
    output logic [7:0] last_char,
    output logic       busy,
    output logic       err_overrun
);

`ifdef LCD_MODEL_BUSY_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    localparam int MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BUSY
    } state_t;

    state_t            state, state_d;
    logic [3:0]        sweep, sweep_d;
    logic [CNT_W-1:0]  cnt, cnt_d;

    logic              en_q;
    logic              rs_q;
    logic [7:0]        data_q;

    logic [7:0]        ddram [16];

    logic              strobe;
    logic              accept;
    logic              data_wr;
    logic              instr;
    logic              is_clear;
    logic              clear_done;
    logic              mem_we;
    logic [3:0]        mem_addr;
    logic [7:0]        mem_wdata;

    // Falling edge of lcd_en; the decoded values are those held while en was high.
    assign strobe     = en_q & ~lcd_en;
    assign busy       = (state != ST_IDLE);
    assign accept     = strobe & ~busy;
    assign data_wr    = accept & rs_q;
    assign instr      = accept & ~rs_q;
    assign is_clear   = instr & (data_q == 8'h01);
    assign clear_done = (state == ST_CLEAR) && (sweep == 4'd15);

    // Bus sampling registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            en_q   <= lcd_en;
            rs_q   <= lcd_rs;
            data_q <= lcd_data;
        end
    end

    // FSM state register; reset (even mid-sweep) restarts the clear from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            sweep <= 4'd0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            sweep <= sweep_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and DDRAM write port.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state;
        sweep_d   = sweep;
        cnt_d     = cnt;
        mem_we    = 1'b0;
        mem_addr  = cursor;
        mem_wdata = data_q;

        case (state)
            ST_IDLE: begin
                if (data_wr) begin
                    mem_we = 1'b1;
                end
                if (is_clear) begin
                    state_d = ST_CLEAR;
                    sweep_d = 4'd0;
                end else if (accept && BUSY_EN) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(CMD_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = sweep;
                mem_wdata = SPACE;
                sweep_d   = sweep + 4'd1;
                if (clear_done) begin
                    if (BUSY_EN) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(CLEAR_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // DDRAM array.
    // NOTE: the array has no reset; the clear sweep entered from reset initialises it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            ddram[mem_addr] <= mem_wdata;
        end
    end

    // Control registers, read port and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor      <= 4'd0;
            inc_mode    <= 1'b1;
            disp_on     <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            func_8bit   <= 1'b1;
            func_2line  <= 1'b0;
            wr_strobe   <= 1'b0;
            last_char   <= SPACE;
            rd_char     <= 8'h00;
            err_overrun <= 1'b0;
        end else begin
            // Read sees the pre-write contents when addressing the cell being written.
            rd_char   <= ddram[rd_addr];
            wr_strobe <= data_wr;

            if (strobe && busy) begin
                err_overrun <= 1'b1;
            end

            if (clear_done) begin
                cursor   <= 4'd0;
                inc_mode <= 1'b1;
            end else if (data_wr) begin
                last_char <= data_q;
                // 4-bit arithmetic gives the 15->0 / 0->15 wrap.
                cursor    <= inc_mode ? cursor + 4'd1 : cursor - 4'd1;
            end else if (instr) begin
                casez (data_q)
                    8'b1???????: cursor <= data_q[3:0];
                    8'b001?????: begin
                        func_8bit  <= data_q[4];
                        func_2line <= data_q[3];
                    end
                    8'b00001???: begin
                        disp_on   <= data_q[2];
                        cursor_on <= data_q[1];
                        blink_on  <= data_q[0];
                    end
                    8'b000001??: inc_mode <= data_q[1];
                    8'b0000001?: cursor   <= 4'd0;
                    // CGRAM address, shift, clear (handled by the FSM) and no-op.
                    default: ;
                endcase
            end
        end
    end

endmodule
